mult_unit: RTL

Sequential 8-bit shift-add multiplier sitting beside the ALU in the mini-mips multicycle datapath. It takes the same two register operands the ALU sees and produces a 16-bit product split into hi/lo bytes for the result mux. The controller launches it with a one-cycle start pulse and holds its FSM while busy is high. It reuses the byte-wide operand path instead of widening the ALU.

---
 rtl/mips_pkg.sv | 5 +
 rtl/mult_unit.sv | 70 +++++++
 2 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and state types for the mini-mips datapath
package mips_pkg;
  localparam int MULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;
endpackage

// File: rtl/mult_unit.sv
// mult_unit: sequential shift-add multiplier producing a 2*WIDTH product as hi/lo; define MULT_SIGNED_EN for two's-complement operands
module mult_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  mult_state_t state, state_n;
  logic [2*WIDTH-1:0] mcand, acc, acc_n, result;
  logic [WIDTH-1:0] mplier, a_mag, b_mag;
  logic [CW-1:0] count;
  logic last, launch;
`ifdef MULT_SIGNED_EN
  logic neg;
  assign a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_op && b[WIDTH-1]) ? -b : b;
  assign result = neg ? -acc_n : acc_n;
  always_ff @(posedge clk)
    if (reset) neg <= 1'b0;
    else if (launch) neg <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
  logic unused_signed;
  assign unused_signed = signed_op;
  assign a_mag = a;
  assign b_mag = b;
  assign result = acc_n;
`endif
  always_comb begin
    launch = state == IDLE && start;
    last = count == CW'(WIDTH-1);
    acc_n = acc + (mplier[0] ? mcand : '0);
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      count <= '0;
      {hi, lo} <= '0;
    end else if (launch) begin
      mcand <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc <= '0;
      count <= '0;
    end else if (state == RUN) begin
      acc <= acc_n;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      count <= count + 1'b1;
      if (last) {hi, lo} <= result;
    end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule
